// File: rtl/lc3b_types.sv
// Shared types for the memory arbiter: FSM state encoding, default word/mask
// widths and a small index-width helper.
package lc3b_types;

  localparam int WORD_W = 16;
  localparam int MASK_W = WORD_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RECOVER = 2'd2
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Channel-side and memory-side signals of the arbiter. The slave modport is
// the arbiter; the master modport is the requesters plus the downstream memory.
interface mem_arbiter_if
  import lc3b_types::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = WORD_W
);
  localparam int MW = DATA_WIDTH / 8;

  logic [NUM_CH-1:0]                 ch_read;
  logic [NUM_CH-1:0]                 ch_write;
  logic [NUM_CH-1:0][MW-1:0]         ch_wmask;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] ch_address;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_wdata;
  logic [NUM_CH-1:0]                 ch_resp;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_rdata;

  logic                  mem_read;
  logic                  mem_write;
  logic [MW-1:0]         mem_wmask;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_resp;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  ch_read, ch_write, ch_wmask, ch_address, ch_wdata, mem_resp, mem_rdata,
    output ch_resp, ch_rdata, mem_read, mem_write, mem_wmask, mem_address, mem_wdata
  );

  modport master (
    output ch_read, ch_write, ch_wmask, ch_address, ch_wdata, mem_resp, mem_rdata,
    input  ch_resp, ch_rdata, mem_read, mem_write, mem_wmask, mem_address, mem_wdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping,
// returned both one-hot and as an index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = '0;
    for (int k = 0; k < N; k++) begin
      c = IW'((int'(ptr) + k) % N);
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter funnelling NUM_CH request channels onto one memory port,
// one outstanding transaction at a time, with a one-cycle recovery gap.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = WORD_W
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int MW = DATA_WIDTH / 8;
  localparam int IW = idx_w(NUM_CH);

  arb_state_e state, state_nxt;

  logic [IW-1:0]         rr_ptr, grant_idx, pick_idx;
  logic [NUM_CH-1:0]     grant_oh, pick_oh, req;
  logic                  pick_any, done;
  logic                  cmd_read, cmd_write;
  logic [MW-1:0]         cmd_wmask;
  logic [ADDR_WIDTH-1:0] cmd_address;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  assign req  = bus.ch_read | bus.ch_write;
  assign done = (state == BUSY) && bus.mem_resp;

  rr_arbiter #(.N(NUM_CH), .IW(IW)) u_rr (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_oh),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = BUSY;
      BUSY:    if (bus.mem_resp) state_nxt = RECOVER;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command is captured once at grant so the memory side sees a stable request
  // even if the channel's inputs wiggle afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      grant_idx   <= '0;
      grant_oh    <= '0;
      cmd_read    <= 1'b0;
      cmd_write   <= 1'b0;
      cmd_wmask   <= '0;
      cmd_address <= '0;
      cmd_wdata   <= '0;
    end else begin
      if (state == IDLE && pick_any) begin
        grant_idx   <= pick_idx;
        grant_oh    <= pick_oh;
        cmd_write   <= bus.ch_write[pick_idx];
        cmd_read    <= bus.ch_read[pick_idx] & ~bus.ch_write[pick_idx];
        cmd_wmask   <= bus.ch_wmask[pick_idx];
        cmd_address <= bus.ch_address[pick_idx];
        cmd_wdata   <= bus.ch_wdata[pick_idx];
      end
      if (done)
        rr_ptr <= (grant_idx == IW'(NUM_CH - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

  always_comb begin
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_wmask   = '0;
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    bus.ch_resp     = '0;
    bus.ch_rdata    = '0;
    if (state == BUSY) begin
      bus.mem_read    = cmd_read;
      bus.mem_write   = cmd_write;
      bus.mem_wmask   = cmd_wmask;
      bus.mem_address = cmd_address;
      bus.mem_wdata   = cmd_wdata;
    end
    if (done) begin
      bus.ch_resp             = grant_oh;
      bus.ch_rdata[grant_idx] = bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter (4 channels): directed scenarios plus random traffic,
// each cycle compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [MW-1:0] mask;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  cmd_t req_cmd [N];
  int   idle_cnt[N];

  // reference model: phase 0 idle, 1 serving m_ch, 2 cooling off
  int   m_phase, m_ch, m_ptr, m_busy;
  cmd_t m_cmd;

  bit            rst_v, rand_mode, oneshot, spurious;
  int            resp_delay;
  logic [DW-1:0] rdata_dir;
  int            obs_grants[$];
  logic [DW-1:0] last_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    int   k;
    k       = $urandom_range(0, 3);
    c.rd    = (k != 2);
    c.wr    = (k >= 2);
    c.mask  = MW'($urandom);
    c.addr  = AW'($urandom);
    c.wdata = DW'($urandom);
    return c;
  endfunction

  function automatic bit requesting(input int c);
    return req_cmd[c].rd || req_cmd[c].wr;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ch = 0; m_ptr = 0; m_busy = 0; m_cmd = '0;
  endtask

  task automatic clear_reqs();
    for (int c = 0; c < N; c++) begin
      req_cmd[c]  = '0;
      idle_cnt[c] = 0;
    end
  endtask

  task automatic step();
    logic                  mresp;
    logic [DW-1:0]         mrd;
    logic                  e_rd, e_wr;
    logic [MW-1:0]         e_mask;
    logic [AW-1:0]         e_addr;
    logic [DW-1:0]         e_wdata;
    logic [N-1:0]          e_resp;
    logic [N-1:0][DW-1:0]  e_rdata;
    int                    done_ch;
    bit                    found;
    @(negedge clk);
    rst = rst_v;
    if (rand_mode) begin
      mresp = ($urandom_range(0, 2) == 0);
      mrd   = DW'($urandom);
    end else begin
      mresp = spurious || (m_phase == 1 && m_busy >= resp_delay);
      mrd   = rdata_dir;
    end
    bus.mem_resp  = mresp;
    bus.mem_rdata = mrd;
    for (int c = 0; c < N; c++) begin
      bus.ch_read[c]    = req_cmd[c].rd;
      bus.ch_write[c]   = req_cmd[c].wr;
      bus.ch_wmask[c]   = req_cmd[c].mask;
      bus.ch_address[c] = req_cmd[c].addr;
      bus.ch_wdata[c]   = req_cmd[c].wdata;
    end
    #1;
    e_rd = 1'b0; e_wr = 1'b0; e_mask = '0; e_addr = '0; e_wdata = '0;
    e_resp = '0; e_rdata = '0;
    if (!rst_v && m_phase == 1) begin
      e_wr    = m_cmd.wr;
      e_rd    = m_cmd.rd && !m_cmd.wr;
      e_mask  = m_cmd.mask;
      e_addr  = m_cmd.addr;
      e_wdata = m_cmd.wdata;
      if (mresp) begin
        e_resp[m_ch]  = 1'b1;
        e_rdata[m_ch] = mrd;
      end
    end
    chk("mem_read",    64'(bus.mem_read),    64'(e_rd));
    chk("mem_write",   64'(bus.mem_write),   64'(e_wr));
    chk("mem_wmask",   64'(bus.mem_wmask),   64'(e_mask));
    chk("mem_address", 64'(bus.mem_address), 64'(e_addr));
    chk("mem_wdata",   64'(bus.mem_wdata),   64'(e_wdata));
    chk("ch_resp",     64'(bus.ch_resp),     64'(e_resp));
    chk("ch_rdata",    64'(bus.ch_rdata),    64'(e_rdata));
    for (int c = 0; c < N; c++)
      if (bus.ch_resp[c] === 1'b1) begin
        obs_grants.push_back(c);
        last_rdata = bus.ch_rdata[c];
      end
    // advance the model across the coming rising edge
    done_ch = -1;
    if (rst_v) model_reset();
    else begin
      case (m_phase)
        0: begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            if (!found && requesting((m_ptr + k) % N)) begin
              found   = 1'b1;
              m_ch    = (m_ptr + k) % N;
              m_cmd   = req_cmd[m_ch];
              m_phase = 1;
              m_busy  = 0;
            end
          end
        end
        1: if (mresp) begin
          done_ch = m_ch;
          m_ptr   = (m_ch + 1) % N;
          m_phase = 2;
        end else m_busy++;
        default: m_phase = 0;
      endcase
    end
    for (int c = 0; c < N; c++) begin
      if (c == done_ch) begin
        if (rand_mode) begin
          if ($urandom_range(0, 1) == 1) req_cmd[c] = rand_cmd();
          else begin
            req_cmd[c]  = '0;
            idle_cnt[c] = $urandom_range(0, 4);
          end
        end else if (oneshot) req_cmd[c] = '0;
      end else if (rand_mode && !requesting(c)) begin
        if (idle_cnt[c] == 0) req_cmd[c] = rand_cmd();
        else idle_cnt[c]--;
      end
    end
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    repeat (2) step();
    rst_v = 1'b0;
  endtask

  initial begin
    bus.ch_read = '0; bus.ch_write = '0; bus.ch_wmask = '0;
    bus.ch_address = '0; bus.ch_wdata = '0;
    bus.mem_resp = 1'b0; bus.mem_rdata = '0;
    rand_mode = 1'b0; oneshot = 1'b1; spurious = 1'b0;
    resp_delay = 0; rdata_dir = '0;
    clear_reqs();
    model_reset();

    // reset holds everything quiet even with a request and a stray mem_resp
    rst_v = 1'b1;
    req_cmd[0].rd = 1'b1;
    spurious = 1'b1;
    repeat (3) step();
    chk("rst_no_grant", 64'(obs_grants.size()), 64'd0);
    clear_reqs();
    spurious = 1'b0;
    rst_v = 1'b0;
    step();

    // single read on ch0, memory answers on the third BUSY cycle
    obs_grants.delete();
    req_cmd[0] = '{rd: 1'b1, wr: 1'b0, mask: '0, addr: 16'h1234, wdata: '0};
    resp_delay = 2; rdata_dir = 16'hBEEF;
    repeat (8) step();
    chk("rd_count", 64'(obs_grants.size()), 64'd1);
    if (obs_grants.size() > 0) chk("rd_chan", 64'(obs_grants[0]), 64'd0);
    chk("rd_rdata", 64'(last_rdata), 64'hBEEF);

    // masked write on ch1
    obs_grants.delete();
    req_cmd[1] = '{rd: 1'b0, wr: 1'b1, mask: 2'b10, addr: 16'h0040, wdata: 16'hA55A};
    resp_delay = 3; rdata_dir = 16'h1111;
    repeat (9) step();
    chk("wr_count", 64'(obs_grants.size()), 64'd1);
    if (obs_grants.size() > 0) chk("wr_chan", 64'(obs_grants[0]), 64'd1);

    // read+write together on ch0 behaves as a write
    obs_grants.delete();
    req_cmd[0] = '{rd: 1'b1, wr: 1'b1, mask: 2'b11, addr: 16'h0777, wdata: 16'h5A5A};
    resp_delay = 1;
    repeat (7) step();
    chk("rw_count", 64'(obs_grants.size()), 64'd1);

    // ch0 and ch1 contend continuously from reset
    do_reset();
    obs_grants.delete();
    oneshot = 1'b0;
    req_cmd[0] = '{rd: 1'b1, wr: 1'b0, mask: '0, addr: 16'h0100, wdata: '0};
    req_cmd[1] = '{rd: 1'b0, wr: 1'b1, mask: 2'b01, addr: 16'h0200, wdata: 16'h00CC};
    resp_delay = 1; rdata_dir = 16'h2222;
    repeat (20) step();
    chk("cont_count_ge4", 64'(obs_grants.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < obs_grants.size(); i++)
      chk($sformatf("cont_order%0d", i), 64'(obs_grants[i]), 64'(i % 2));

    // all four request, memory always answering (also in IDLE/RECOVER)
    do_reset();
    obs_grants.delete();
    for (int c = 0; c < N; c++)
      req_cmd[c] = '{rd: 1'b1, wr: 1'b0, mask: '0, addr: AW'(16'h0A00 + c), wdata: '0};
    spurious = 1'b1; rdata_dir = 16'h3333;
    repeat (25) step();
    chk("rr4_count_ge5", 64'(obs_grants.size() >= 5), 64'd1);
    for (int i = 0; i < 5 && i < obs_grants.size(); i++)
      chk($sformatf("rr4_order%0d", i), 64'(obs_grants[i]), 64'(i % 4));
    clear_reqs();
    oneshot = 1'b1;
    repeat (3) step();
    obs_grants.delete();
    repeat (5) step();
    chk("spurious_idle", 64'(obs_grants.size()), 64'd0);

    // asynchronous reset in the middle of a transaction
    do_reset();
    spurious = 1'b0; resp_delay = 0;
    req_cmd[2] = '{rd: 1'b1, wr: 1'b0, mask: '0, addr: 16'h2222, wdata: '0};
    repeat (5) step();
    req_cmd[3] = '{rd: 1'b1, wr: 1'b0, mask: '0, addr: 16'h3333, wdata: '0};
    resp_delay = 100;
    repeat (4) step();
    chk("pre_rst_busy", 64'(m_phase), 64'd1);
    req_cmd[1] = '{rd: 1'b1, wr: 1'b0, mask: '0, addr: 16'h1111, wdata: '0};
    #2;
    bus.mem_resp = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_mem_read", 64'(bus.mem_read),    64'd0);
    chk("arst_mem_addr", 64'(bus.mem_address), 64'd0);
    chk("arst_ch_resp",  64'(bus.ch_resp),     64'd0);
    chk("arst_ch_rdata", 64'(bus.ch_rdata),    64'd0);
    model_reset();
    obs_grants.delete();
    rst_v = 1'b1; spurious = 1'b1;
    step();
    rst_v = 1'b0;
    repeat (4) step();
    chk("arst_next_count_ge1", 64'(obs_grants.size() >= 1), 64'd1);
    if (obs_grants.size() > 0) chk("arst_next_chan", 64'(obs_grants[0]), 64'd1);

    // random traffic
    do_reset();
    clear_reqs();
    for (int c = 0; c < N; c++) idle_cnt[c] = $urandom_range(0, 3);
    spurious = 1'b0;
    rand_mode = 1'b1;
    repeat (1500) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2, number of requesting channels (legal 2..8).
REQ-002 Parameter ADDR_WIDTH, default 16, address width in bits.
REQ-003 Parameter DATA_WIDTH, default 16, data width in bits; multiple of 8; mask width MW = DATA_WIDTH/8.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-005 Port list (name, direction, width, meaning):
- ch_read  in  NUM_CH  per-channel read request
- ch_write  in  NUM_CH  per-channel write request
- ch_wmask  in  NUM_CH*MW  per-channel byte enables
- ch_address  in  NUM_CH*ADDR_WIDTH  per-channel address
- ch_wdata  in  NUM_CH*DATA_WIDTH  per-channel write data
- ch_resp  out  NUM_CH  per-channel completion pulse
- ch_rdata  out  NUM_CH*DATA_WIDTH  per-channel read data
- mem_read  out  1  downstream read
- mem_write  out  1  downstream write
- mem_wmask  out  MW  downstream byte enables
- mem_address  out  ADDR_WIDTH  downstream address
- mem_wdata  out  DATA_WIDTH  downstream write data
- mem_resp  in  1  downstream completion
- mem_rdata  in  DATA_WIDTH  downstream read data

Function
REQ-006 The block SHALL implement a three-state FSM: IDLE, BUSY, RECOVER.
REQ-007 Channel i is requesting when ch_read[i] or ch_write[i] is 1; a requester holds its command stable until its ch_resp pulse.
REQ-008 IDLE: with any request, grant the first requesting channel at or after rr_ptr (wrapping modulo NUM_CH), register that channel's command, and go to BUSY next edge; with no request, stay in IDLE.
REQ-009 Read and write both asserted on one channel SHALL be treated as a write (mem_read=0, mem_write=1).
REQ-010 BUSY: mem_* SHALL be driven from the registered command, stable, until mem_resp=1.
REQ-011 On mem_resp=1 in BUSY: in the same cycle, ch_resp[grant]=1 and ch_rdata[grant]=mem_rdata; next state RECOVER; rr_ptr <= (grant+1) mod NUM_CH.
REQ-012 ch_resp SHALL be one-hot or zero and SHALL never be asserted outside the BUSY cycle in which mem_resp=1.
REQ-013 RECOVER SHALL last exactly one cycle with mem_read=mem_write=0, then return to IDLE; this prevents re-granting a channel that is still deasserting.
REQ-014 Outside BUSY: mem_read=0, mem_write=0, mem_wmask=0, mem_address=0, mem_wdata=0; ch_rdata for non-granted channels=0.
REQ-015 Minimum latency: request seen in IDLE at cycle T -> mem_* valid at T+1 -> ch_resp at the mem_resp cycle (>=T+1); back-to-back grants spaced by at least 3 cycles.
REQ-016 Requests arriving during BUSY/RECOVER wait; no request is dropped; starvation is bounded by NUM_CH-1 intervening grants.
REQ-017 mem_resp in IDLE or RECOVER SHALL be ignored.

Reset
REQ-018 rst=1 SHALL immediately force state=IDLE, rr_ptr=0, registered command=0, all outputs 0, independent of clk.
REQ-019 Reset during BUSY abandons the transaction: no ch_resp issued; after release the block restarts arbitration from channel 0.

Structure
REQ-020 The FSM state enum and the default width constants (16-bit word, 2-bit mask) belong in lc3b_types; the parameters stay local.
REQ-021 One sub-module, rr_arbiter (combinational round-robin priority pick: request vector + pointer -> one-hot grant + index), is natural; everything else is in mem_arbiter.

Verification
REQ-022 Single read: ch_read[0]=1, addr 0x1234; memory resp after 2 cycles with 0xBEEF -> mem_read=1 addr 0x1234 from T+1, ch_resp[0] pulse with ch_rdata[0]=0xBEEF, RECOVER, IDLE.
REQ-023 Contention: ch0 and ch1 both request continuously from reset -> grants alternate 0,1,0,1; each ch_resp is one-hot.
REQ-024 Write with mask: ch_write[1]=1, addr 0x0040, wdata 0xA55A, wmask 2'b10 -> mem_write=1, mem_wmask=2'b10, mem_wdata=0xA55A, held until mem_resp.
REQ-025 Read+write both set on ch0 -> mem_write=1, mem_read=0.
REQ-026 rst asserted mid-BUSY (mem_resp pending) -> outputs 0 asynchronously; a late mem_resp produces no ch_resp; the next grant goes to the lowest requesting channel.
REQ-027 NUM_CH=4, all four requesting -> grant order 0,1,2,3,0; spurious mem_resp in IDLE -> no ch_resp.
